td4_pmem_loader: RTL and testbench

Program-memory responder for the 4-bit TD4 core: a 16×8 instruction store that answers the core's `MEM_ADDR` with `MEM_DATA`. It is filled at run time by a bit-serial loader state machine. While a load is in progress it serves a fixed `JMP 0` opcode, so the core spins at address 0 and starts the new program from address 0 once loading ends.

---
 rtl/td4_pkg.sv | 13 +
 rtl/td4_pmem_array.sv | 24 ++
 rtl/td4_pmem_loader.sv | 90 +++++++++
 tb/tb_td4_pmem_loader.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// td4_pkg: shared loader state encoding and TD4 program-memory constants.
package td4_pkg;
  localparam int TD4_BYTE_W = 8;
  localparam int TD4_NIBBLE_W = 4;
  localparam int TD4_MEM_DEPTH = 16;
  localparam logic [TD4_BYTE_W-1:0] TD4_OP_JMP0 = 8'hF0;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE = 2'd2,
    ST_WAIT_LOW = 2'd3
  } td4_state_e;
endpackage

// File: rtl/td4_pmem_array.sv
// td4_pmem_array: 16x8 instruction store, async reset fill, one sync write port, one comb read port.
module td4_pmem_array
  import td4_pkg::*;
#(
  parameter logic [TD4_BYTE_W-1:0] RESET_FILL = 8'h00
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    we,
  input  logic [TD4_NIBBLE_W-1:0] waddr,
  input  logic [TD4_BYTE_W-1:0]   wdata,
  input  logic [TD4_NIBBLE_W-1:0] raddr,
  output logic [TD4_BYTE_W-1:0]   rdata
);
  logic [TD4_BYTE_W-1:0] mem [TD4_MEM_DEPTH];
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < TD4_MEM_DEPTH; i++) mem[i] <= RESET_FILL;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/td4_pmem_loader.sv
// td4_pmem_loader: TD4 program memory with bit-serial run-time loader; serves JMP 0 while loading.
// Optional build macro TD4_PMEM_CHECKSUM_EN enables the CHECKSUM accumulator.
module td4_pmem_loader
  import td4_pkg::*;
#(
  parameter logic [TD4_BYTE_W-1:0] BUSY_OPCODE = TD4_OP_JMP0,
  parameter logic [TD4_BYTE_W-1:0] RESET_FILL = 8'h00
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [TD4_NIBBLE_W-1:0] MEM_ADDR,
  output logic [TD4_BYTE_W-1:0]   MEM_DATA,
  input  logic                    SER_FRAME,
  input  logic                    SER_VALID,
  input  logic                    SER_DIN,
  output logic                    LOAD_BUSY,
  output logic                    LOAD_DONE,
  output logic [4:0]              BYTE_COUNT,
  output logic [TD4_BYTE_W-1:0]   CHECKSUM
);
  td4_state_e state;
  logic [6:0] shift;
  logic [2:0] bit_cnt;
  logic [TD4_NIBBLE_W-1:0] wr_addr;
  logic [4:0] byte_cnt;
  logic we;
  logic start;
  logic [TD4_BYTE_W-1:0] wbyte;
  logic [TD4_BYTE_W-1:0] rdata;
  assign start = state == ST_IDLE && SER_FRAME;
  assign wbyte = {shift, SER_DIN};
  // a frame drop wins over a completing strobe, so the frame term gates the write
  assign we = state == ST_SHIFT && SER_FRAME && SER_VALID && bit_cnt == 3'd7;
  assign LOAD_BUSY = state == ST_SHIFT;
  assign LOAD_DONE = state == ST_DONE;
  assign BYTE_COUNT = byte_cnt;
  assign MEM_DATA = LOAD_BUSY ? BUSY_OPCODE : rdata;
  td4_pmem_array #(.RESET_FILL(RESET_FILL)) u_array (
    .CLK(CLK),
    .RST_N(RST_N),
    .we(we),
    .waddr(wr_addr),
    .wdata(wbyte),
    .raddr(MEM_ADDR),
    .rdata(rdata)
  );
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      shift <= '0;
      bit_cnt <= '0;
      wr_addr <= '0;
      byte_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (SER_FRAME) begin
          state <= ST_SHIFT;
          bit_cnt <= '0;
          wr_addr <= '0;
          byte_cnt <= '0;
        end
        ST_SHIFT: if (!SER_FRAME) begin
          state <= ST_IDLE;
        end else if (SER_VALID) begin
          shift <= {shift[5:0], SER_DIN};
          bit_cnt <= bit_cnt + 3'd1;
          if (we) begin
            wr_addr <= wr_addr + 4'd1;
            byte_cnt <= byte_cnt + 5'd1;
            if (byte_cnt == 5'd15) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_WAIT_LOW;
        ST_WAIT_LOW: if (!SER_FRAME) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
`ifdef TD4_PMEM_CHECKSUM_EN
  logic [TD4_BYTE_W-1:0] sum;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sum <= '0;
    else if (start) sum <= '0;
    else if (we) sum <= sum + wbyte;
  end
  assign CHECKSUM = sum;
`else
  assign CHECKSUM = 8'h00;
`endif
endmodule

// File: tb/tb_td4_pmem_loader.sv
// tb_td4_pmem_loader: directed table-driven checks of load, abort, extra bits and async reset.
module tb_td4_pmem_loader;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [3:0] MEM_ADDR = '0;
  logic SER_FRAME = 1'b0;
  logic SER_VALID = 1'b0;
  logic SER_DIN = 1'b0;
  logic [7:0] MEM_DATA;
  logic LOAD_BUSY;
  logic LOAD_DONE;
  logic [4:0] BYTE_COUNT;
  logic [7:0] CHECKSUM;
`ifdef TD4_PMEM_CHECKSUM_EN
  localparam logic [7:0] SUM_FULL = 8'h78;
  localparam logic [7:0] SUM_ABORT = 8'h1F;
`else
  localparam logic [7:0] SUM_FULL = 8'h00;
  localparam logic [7:0] SUM_ABORT = 8'h00;
`endif
  td4_pmem_loader dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .MEM_ADDR(MEM_ADDR),
    .MEM_DATA(MEM_DATA),
    .SER_FRAME(SER_FRAME),
    .SER_VALID(SER_VALID),
    .SER_DIN(SER_DIN),
    .LOAD_BUSY(LOAD_BUSY),
    .LOAD_DONE(LOAD_DONE),
    .BYTE_COUNT(BYTE_COUNT),
    .CHECKSUM(CHECKSUM)
  );
  always #5 CLK = ~CLK;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } vec_t;
  vec_t vt [16];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic run_table(input string name);
    for (int i = 0; i < 16; i++) begin
      MEM_ADDR = vt[i].addr;
      #1;
      check($sformatf("%s[%0d]", name, i), {24'd0, MEM_DATA}, {24'd0, vt[i].data});
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic send_bits(input logic [7:0] b, input int n);
    SER_VALID = 1'b1;
    for (int k = 7; k > 7 - n; k--) begin
      SER_DIN = b[k];
      cyc();
    end
    SER_VALID = 1'b0;
  endtask
  task automatic check_status(input string name, input logic busy, input logic done,
                              input logic [4:0] cnt, input logic [7:0] sum);
    check({name, ".busy"}, {31'd0, LOAD_BUSY}, {31'd0, busy});
    check({name, ".done"}, {31'd0, LOAD_DONE}, {31'd0, done});
    check({name, ".count"}, {27'd0, BYTE_COUNT}, {27'd0, cnt});
    check({name, ".sum"}, {24'd0, CHECKSUM}, {24'd0, sum});
  endtask
  initial begin
    // reset: every word reads RESET_FILL
    #12;
    check_status("reset", 1'b0, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 16; i++) vt[i] = '{addr: 4'(i), data: 8'h00};
    run_table("reset_mem");
    RST_N = 1'b1;
    cyc();
    check_status("post_reset", 1'b0, 1'b0, 5'd0, 8'h00);
    // full load of 8'h10+i
    SER_FRAME = 1'b1;
    cyc();
    check_status("frame_start", 1'b1, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      send_bits(8'(8'h10 + i), 8);
      if (i < 15) begin
        MEM_ADDR = 4'(i);
        #1;
        check($sformatf("busy_opcode[%0d]", i), {24'd0, MEM_DATA}, 32'hF0);
        check($sformatf("load_count[%0d]", i), {27'd0, BYTE_COUNT}, 32'(i + 1));
        check($sformatf("load_busy[%0d]", i), {31'd0, LOAD_BUSY}, 32'd1);
      end
    end
    check_status("load_end", 1'b0, 1'b1, 5'd16, SUM_FULL);
    MEM_ADDR = 4'd3;
    #1;
    check("after_done_addr3", {24'd0, MEM_DATA}, 32'h13);
    cyc();
    check_status("done_pulse_end", 1'b0, 1'b0, 5'd16, SUM_FULL);
    // extra bits with frame held high must be ignored in WAIT_LOW
    send_bits(8'hFF, 8);
    send_bits(8'h00, 8);
    check_status("extra_bits", 1'b0, 1'b0, 5'd16, SUM_FULL);
    for (int i = 0; i < 16; i++) vt[i] = '{addr: 4'(i), data: 8'(8'h10 + i)};
    run_table("load_mem");
    SER_FRAME = 1'b0;
    cyc();
    check_status("frame_drop", 1'b0, 1'b0, 5'd16, SUM_FULL);
    // abort after two bytes and five bits
    SER_FRAME = 1'b1;
    cyc();
    check_status("abort_start", 1'b1, 1'b0, 5'd0, 8'h00);
    send_bits(8'hB5, 8);
    send_bits(8'h6A, 8);
    send_bits(8'hFF, 5);
    SER_FRAME = 1'b0;
    cyc();
    check_status("abort", 1'b0, 1'b0, 5'd2, SUM_ABORT);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("abort_no_done[%0d]", i), {31'd0, LOAD_DONE}, 32'd0);
    end
    vt[0].data = 8'hB5;
    vt[1].data = 8'h6A;
    run_table("abort_mem");
    // frame drop coinciding with the 8th strobe: drop wins, no write
    SER_FRAME = 1'b1;
    cyc();
    send_bits(8'h00, 7);
    SER_VALID = 1'b1;
    SER_DIN = 1'b0;
    SER_FRAME = 1'b0;
    cyc();
    SER_VALID = 1'b0;
    check_status("drop_vs_8th", 1'b0, 1'b0, 5'd0, 8'h00);
    MEM_ADDR = 4'd0;
    #1;
    check("drop_vs_8th_mem0", {24'd0, MEM_DATA}, 32'hB5);
    // async reset in the middle of byte 7
    SER_FRAME = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) send_bits(8'(8'hA0 + i), 8);
    send_bits(8'hE0, 3);
    check_status("pre_async", 1'b1, 1'b0, 5'd6, 8'hXX === 8'hXX ? CHECKSUM : 8'h00);
    #2;
    RST_N = 1'b0;
    #1;
    check_status("async_reset", 1'b0, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 16; i++) vt[i] = '{addr: 4'(i), data: 8'h00};
    run_table("async_mem");
    SER_FRAME = 1'b0;
    RST_N = 1'b1;
    cyc();
    check_status("after_async", 1'b0, 1'b0, 5'd0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
